// File: rtl/mix_bias_add.sv
// Bias-add stage of the mix layer: drives the bias ROM address, aligns the registered
// ROM word with each data element, adds with saturation. Optional ReLU via MIX_BIAS_RELU_EN.
module mix_bias_add #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned HID     = 16,
  parameter int unsigned N_LAYER = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        layer_sel,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_bias,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W = (HID > 1) ? $clog2(HID) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    s1_idx_q;
  logic [DATA_W-1:0]   base_q;
  logic [DATA_W-1:0]   s1_data_q;
  logic                s1_valid_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_last_q;
  logic                done_q;
  logic                err_q;

  logic                s2_load;
  logic                adv;
  logic                accept;
  logic                last_hs;
  logic                layer_ok;
  logic                cnt_last;
  logic [DATA_W:0]     sum_c;
  logic [DATA_W-1:0]   sat_c;
  logic [DATA_W-1:0]   res_c;

  assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
  assign adv      = !s1_valid_q || s2_load;
  assign in_ready = (state_q == RUN) && adv;
  assign accept   = in_valid && in_ready;
  assign last_hs  = out_valid_q && out_ready && out_last_q;
  assign layer_ok = 32'(layer_sel) < N_LAYER;
  assign cnt_last = (cnt_q == CNT_W'(HID - 1));
  assign busy     = (state_q != IDLE);

  // While s1 is stalled the held element's address is re-presented so rom_bias stays aligned.
  assign rom_addr = base_q + DATA_W'(adv ? cnt_q : s1_idx_q);

  assign sum_c = {s1_data_q[DATA_W-1], s1_data_q} + {rom_bias[DATA_W-1], rom_bias};

  always_comb begin
    sat_c = sum_c[DATA_W-1:0];
    if (sum_c[DATA_W] != sum_c[DATA_W-1]) begin
      sat_c = sum_c[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
`ifdef MIX_BIAS_RELU_EN
    res_c = sat_c[DATA_W-1] ? '0 : sat_c;
`else
    res_c = sat_c;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      s1_idx_q    <= '0;
      base_q      <= '0;
      s1_data_q   <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start) begin
            if (layer_ok) begin
              state_q <= RUN;
              base_q  <= DATA_W'(32'(layer_sel) * HID);
              cnt_q   <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            if (cnt_last) state_q <= DRAIN;
            else          cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (last_hs) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (accept) begin
        s1_valid_q <= 1'b1;
        s1_data_q  <= in_data;
        s1_idx_q   <= cnt_q;
      end else if (s2_load) begin
        s1_valid_q <= 1'b0;
      end

      if (s2_load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= res_c;
        out_last_q  <= (s1_idx_q == CNT_W'(HID - 1));
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mix_bias_add.sv
// Scoreboard bench for mix_bias_add with a registered bias-ROM model.
module tb_mix_bias_add;
  localparam int unsigned W   = 16;
  localparam int unsigned HID = 16;
  localparam int unsigned NL  = 3;

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [1:0]   layer_sel = 2'd0;
  logic         in_valid = 1'b0, in_ready;
  logic [W-1:0] in_data = '0, rom_addr, rom_bias = '0, out_data;
  logic         out_valid, out_ready = 1'b1, out_last, busy, done, err;

  mix_bias_add #(.DATA_W(W), .HID(HID), .N_LAYER(NL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .layer_sel(layer_sel),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rom_addr(rom_addr), .rom_bias(rom_bias),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [NL*HID];
  always @(posedge clk) rom_bias <= (int'(rom_addr) < NL*HID) ? mem[rom_addr] : '0;

  typedef struct { logic [W-1:0] data; logic last; int cyc; } exp_t;
  exp_t sb[$];

  int n_cmp = 0, n_err = 0, cyc = 0, done_cnt = 0, n_obs = 0;
  bit bp_mode = 1'b0;
  logic [W-1:0] din [HID];
  logic [W-1:0] obs [HID];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
`ifdef MIX_BIAS_RELU_EN
    if (s < 0) s = 0;
`endif
    return W'(s);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: scoreboard pop, latency, hold-while-stalled, done counting.
  initial begin
    logic [W-1:0] held_d;
    logic         held_l;
    bit           held_v;
    exp_t         e;
    held_v = 1'b0;
    held_d = '0;
    held_l = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_v = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (held_v) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_data", 32'(out_data), 32'(held_d));
          chk("hold_last", 32'(out_last), 32'(held_l));
        end
        held_v = out_valid && !out_ready;
        held_d = out_data;
        held_l = out_last;
        if (out_valid && out_ready) begin
          chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("out_data", 32'(out_data), 32'(e.data));
            chk("out_last", 32'(out_last), 32'(e.last));
            if (!bp_mode) chk("latency", 32'(cyc - e.cyc), 32'd2);
            if (n_obs < HID) begin
              obs[n_obs] = out_data;
              n_obs++;
            end
          end
        end
      end
    end
  end

  task automatic run_pass(input int layer, input bit bp, input bit start_mid, input int rst_at);
    int k, guard, d0;
    k = 0; guard = 0; d0 = done_cnt; n_obs = 0;
    bp_mode = bp;
    @(posedge clk); #1; start = 1'b1; layer_sel = 2'(layer);
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    chk("busy_run", 32'(busy), 32'd1);
    while (k < HID && guard < 2000) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = din[k];
      start    = start_mid && (k == 4);
      layer_sel = start_mid ? 2'd0 : 2'(layer);
      if (rst_at == k) begin
        #2; rst_n = 1'b0; #1;
        chk("rst_async", {25'd0, out_valid, out_last, done, err, busy, in_ready, 1'b0} | 32'(out_data), 32'd0);
        in_valid = 1'b0;
        sb.delete();
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("no_done_after_rst", 32'(done_cnt - d0), 32'd0);
        chk("busy_after_rst", 32'(busy), 32'd0);
        bp_mode = 1'b0;
        return;
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        sb.push_back('{model(din[k], mem[layer*HID + k]), (k == HID - 1), cyc});
        k++;
      end
      guard++;
    end
    chk("in_timeout", 32'(guard < 2000), 32'd1);
    @(posedge clk); #1; in_valid = 1'b0; start = 1'b0;
    guard = 0;
    while (busy && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_timeout", 32'(guard < 500), 32'd1);
    repeat (3) @(negedge clk);
    chk("done_count", 32'(done_cnt - d0), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    bp_mode = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NL*HID; i++) mem[i] = W'($urandom_range(0, 16'hFFFF));
    for (int k = 0; k < HID; k++) mem[HID + k] = W'(k);
    mem[2*HID + 0] = 16'h0200;
    mem[2*HID + 1] = 16'hFE00;
    mem[2*HID + 2] = 16'h0010;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {26'd0, out_valid, out_last, done, err, busy, in_ready} | 32'(out_data), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Layer 1 with b[k]=k
    for (int k = 0; k < HID; k++) din[k] = W'(16'h0100 + k);
    run_pass(1, 1'b0, 1'b0, -1);
    for (int k = 0; k < HID; k++) chk("t1_val", 32'(obs[k]), 32'h0100 + 32'(2*k));

    // Saturation and sign corners on layer 2
    for (int k = 0; k < HID; k++) din[k] = W'($urandom_range(0, 16'hFFFF));
    din[0] = 16'h7F00; din[1] = 16'h8100; din[2] = 16'hFF00;
    run_pass(2, 1'b0, 1'b0, -1);
    chk("sat_pos", 32'(obs[0]), 32'h7FFF);
    chk("sat_neg", 32'(obs[1]), 32'h8000);
`ifdef MIX_BIAS_RELU_EN
    chk("relu_neg", 32'(obs[2]), 32'h0000);
`else
    chk("pass_neg", 32'(obs[2]), 32'hFF10);
`endif

    // Random backpressure on layer 0
    for (int k = 0; k < HID; k++) din[k] = W'($urandom_range(0, 16'hFFFF));
    run_pass(0, 1'b1, 1'b0, -1);
    chk("bp_count", 32'(n_obs), 32'(HID));

    // Invalid layer select
    @(posedge clk); #1; start = 1'b1; layer_sel = 2'd3;
    @(posedge clk); #1; start = 1'b0; layer_sel = 2'd0;
    @(negedge clk);
    chk("err_pulse", 32'(err), 32'd1);
    chk("err_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("err_clear", 32'(err), 32'd0);

    // start during RUN is ignored
    for (int k = 0; k < HID; k++) din[k] = W'($urandom_range(0, 16'hFFFF));
    run_pass(1, 1'b0, 1'b1, -1);

    // Reset mid-pass, then a clean pass restarts at element 0
    run_pass(1, 1'b0, 1'b0, 5);
    for (int k = 0; k < HID; k++) din[k] = W'(16'h0100 + k);
    run_pass(1, 1'b0, 1'b0, -1);
    chk("restart_elem0", 32'(obs[0]), 32'h0100);
    chk("restart_count", 32'(n_obs), 32'(HID));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
